// File: rtl/arb_pkg.sv
// Shared definitions for the req_arbiter slice.
//   arb_state_t : arbiter FSM state encoding (idle, grant active, one-cycle gap)
//   clog2()     : elaboration-time ceil(log2) used to size index and counter fields
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority encoder.
// Searches req upward from index start, wrapping at N-1 -> 0, and reports the
// first requesting index. With start=0 it is a plain lowest-index-first encoder.
// Ports:
//   req   [N]          request vector
//   start [clog2(N)]   index with highest priority this cycle
//   idx   [clog2(N)]   winning index (0 when valid=0)
//   valid              at least one request present
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [clog2(N)-1:0] start,
  output logic [clog2(N)-1:0] idx,
  output logic                valid
);

  localparam int W = clog2(N);

  logic [W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise the tool infers a latch.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((int'(start) + i) % N);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// N-way sequential arbiter for one shared resource.
// A registered one-hot grant is held while the owner keeps requesting, until it
// releases or until MAX_HOLD consecutive grant cycles have elapsed. A preempted
// owner is excluded for one gap cycle so another requester can be served.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : rotating priority, search starts one past the last winner
//   undefined : fixed priority, lowest index wins (pointer tied to 0)
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      [N] level requests, held until served
//   gnt      [N] registered one-hot grant
//   gnt_id   [clog2(N)] index of the granted requester (holds while idle)
//   busy     a grant is active (|gnt)
//   timeout  one-cycle pulse when the current grant was preempted
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic [clog2(N)-1:0] gnt_id,
  output logic                busy,
  output logic                timeout
);

  localparam int IDW = clog2(N);
  // A zero-width counter is not legal, so MAX_HOLD=0 still keeps one bit.
  localparam int HCW = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HCW-1:0] HOLD_SAT  = '1;
  localparam logic [N-1:0]   ONE       = {{(N-1){1'b0}}, 1'b1};

  arb_state_t     state;
  logic [HCW-1:0] hold_cnt;
  logic [IDW-1:0] pre_id;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   pre_mask;
  logic [N-1:0]   pick_req;
  logic [IDW-1:0] pick_idx;
  logic           pick_valid;
  logic           released;
  logic           do_grant;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);
`else
  assign ptr = '0;
`endif

  assign pre_mask = ONE << pre_id;
  assign released = !req[gnt_id];
  assign busy     = |gnt;

  // Only the gap cycle masks out the requester that was just preempted.
  assign pick_req = (state == ST_GAP) ? (req & ~pre_mask) : req;

  rr_prio_pick #(
    .N(N)
  ) u_pick (
    .req  (pick_req),
    .start(ptr),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  // A new grant is issued from idle, from the gap cycle, or back-to-back when
  // the owner releases while someone else is waiting. A release takes
  // precedence over a timeout falling in the same cycle.
  always_comb begin
    do_grant = 1'b0;
    case (state)
      ST_IDLE:  do_grant = pick_valid;
      ST_GAP:   do_grant = pick_valid;
      ST_GRANT: do_grant = released && pick_valid;
      default:  do_grant = 1'b0;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      pre_id   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr      <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      if (do_grant) begin
        state    <= ST_GRANT;
        gnt      <= ONE << pick_idx;
        gnt_id   <= pick_idx;
        hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr      <= (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
`endif
      end else begin
        case (state)
          ST_GRANT: begin
            if (released) begin
              gnt   <= '0;
              state <= ST_IDLE;
            end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
              gnt     <= '0;
              timeout <= 1'b1;
              pre_id  <= gnt_id;
              state   <= ST_GAP;
            end else if (hold_cnt != HOLD_SAT) begin
              // Saturates instead of wrapping when there is no hold limit.
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_GAP:  state <= ST_IDLE;
          ST_IDLE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter (N=4, MAX_HOLD=4). A cycle-level
// reference model tracks who owns the resource and for how many cycles.
// Honors ARB_ROUND_ROBIN_EN the same way the design build does.
module tb_req_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_owner;   // current owner, -1 when nobody holds the grant
  int m_run;     // cycles the current owner has held the grant
  int m_excl;    // requester barred for this cycle after a preemption, -1 none
  int m_last;    // last granted index
  int m_ptr;     // search start
  bit m_tout;

  req_arbiter #(
    .N       (N),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_excl  = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_tout  = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int excl);
    logic [1:0] ii;
    for (int k = 0; k < N; k++) begin
      ii = 2'((m_ptr + k) % N);
      if (r[ii] && int'(ii) != excl) return int'(ii);
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_owner = w;
    m_last  = w;
    m_run   = 1;
`ifdef ARB_ROUND_ROBIN_EN
    m_ptr   = (w + 1) % N;
`endif
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int w;
    m_tout = 1'b0;
    if (m_owner >= 0) begin
      if (!r[2'(m_owner)]) begin
        w = pick(r, -1);
        if (w >= 0) grant_to(w);
        else m_owner = -1;
      end else if (MAX_HOLD != 0 && m_run == MAX_HOLD) begin
        m_tout  = 1'b1;
        m_excl  = m_owner;
        m_owner = -1;
      end else begin
        m_run++;
      end
    end else begin
      w = pick(r, m_excl);
      m_excl = -1;
      if (w >= 0) grant_to(w);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, ".gnt"},     32'(gnt),     32'(exp_gnt));
    check({tag, ".gnt_id"},  32'(gnt_id),  32'(m_last));
    check({tag, ".busy"},    32'(busy),    32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_tout));
  endtask

  // Apply r, advance one rising edge, then compare just after the edge.
  task automatic tick(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  int exp_seq[5] = '{0, 1, 2, 3, 0};
`else
  int exp_seq[5] = '{0, 1, 0, 1, 0};
`endif

  initial begin
    logic [N-1:0] r;
    logic [1:0]   bi;

    // 1: reset with all requests high
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.gnt",     32'(gnt),     32'h0);
    check("rst.busy",    32'(busy),    32'h0);
    check("rst.timeout", 32'(timeout), 32'h0);
    check("rst.gnt_id",  32'(gnt_id),  32'h0);
    req   = 4'b0000;
    rst_n = 1'b1;
    tick(4'b0000, "idle0");
    tick(4'b0000, "idle1");

    // 2: first grant, one-cycle latency
    tick(4'b1010, "t2");
    check("t2.lit_gnt", 32'(gnt), 32'b0010);
    check("t2.lit_id",  32'(gnt_id), 32'd1);

    // 3: release hands over without an idle gap
    tick(4'b1010, "t3.hold");
    tick(4'b1000, "t3.handover");
    check("t3.lit_gnt",  32'(gnt), 32'b1000);
    check("t3.lit_id",   32'(gnt_id), 32'd3);
    check("t3.lit_busy", 32'(busy), 32'd1);
    tick(4'b0000, "t3.release");

    // 4: lone requester is preempted after MAX_HOLD cycles then regranted
    for (int k = 0; k < MAX_HOLD; k++) begin
      tick(4'b0001, "t4.hold");
      check("t4.lit_gnt", 32'(gnt), 32'b0001);
    end
    tick(4'b0001, "t4.tout");
    check("t4.lit_tout", 32'(timeout), 32'd1);
    check("t4.lit_gap",  32'(gnt), 32'd0);
    tick(4'b0001, "t4.idle");
    check("t4.lit_idle", 32'(gnt), 32'd0);
    tick(4'b0001, "t4.regrant");
    check("t4.lit_regrant", 32'(gnt), 32'b0001);
    tick(4'b0000, "t4.release");

    // 5: all requesting, grants ending by timeout
    do_reset();
    for (int k = 0; k < 21; k++) begin
      tick(4'b1111, "t5");
      if (k % 5 == 0) check("t5.seq", 32'(gnt_id), 32'(exp_seq[k / 5]));
    end

    // 6: asynchronous reset during a grant
    do_reset();
    tick(4'b0010, "t6.grant");
    #3;
    rst_n = 1'b0;
    #1;
    check("t6.async_gnt",  32'(gnt),  32'd0);
    check("t6.async_busy", 32'(busy), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    tick(4'b0100, "t6.after");
    check("t6.lit_gnt", 32'(gnt), 32'b0100);
    check("t6.lit_id",  32'(gnt_id), 32'd2);

    // Randomized traffic: requests stay up until served, owners drop randomly
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        bi = 2'(i);
        if (m_owner == i) r[bi] = ($urandom_range(0, 4) != 0);
        else if (r[bi])   r[bi] = ($urandom_range(0, 15) != 0);
        else              r[bi] = ($urandom_range(0, 2) == 0);
      end
      tick(r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
